// File: rtl/pool_pkg.sv
// Shared definitions for the pooling reduction unit: mode codes, log2 helper and signed saturation.
package pool_pkg;

    localparam int MODE_SUM  = 0;
    localparam int MODE_MAX  = 1;
    localparam int MODE_MEAN = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Sign-extends an in_w-bit value and clamps it to the out_w-bit signed range.
    function automatic logic [63:0] sat_signed(input logic [63:0] value, input int in_w, input int out_w);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = $signed(value << (64 - in_w)) >>> (64 - in_w);
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One lane of the pooling reducer: wide accumulator, signed max/sum combine and finalisation.
// POOL_SAT_EN selects clamping instead of wrap-around for sum-mode results.
module pool_lane
    import pool_pkg::*;
#(
    parameter int TOTAL_BITS = 16,
    parameter int WINDOW     = 4,
    parameter int MODE       = MODE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_accept,
    input  logic                  i_first,
    input  logic [TOTAL_BITS-1:0] i_data,
    output logic [TOTAL_BITS-1:0] o_final
);

    localparam int LOG2W = clog2(WINDOW);
    localparam int ACC_W = TOTAL_BITS + LOG2W;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_beat;
    logic signed [ACC_W-1:0] w_next;

    assign w_beat = ACC_W'($signed(i_data));

    // The first beat of a window overwrites whatever a flushed window left behind.
    generate
        if (MODE == MODE_MAX) begin : g_max
            assign w_next = i_first ? w_beat : ((w_beat > r_acc) ? w_beat : r_acc);
        end else begin : g_add
            assign w_next = i_first ? w_beat : (r_acc + w_beat);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_accept) begin
            r_acc <= w_next;
        end
    end

    generate
        if (MODE == MODE_MEAN) begin : g_finMean
            logic signed [ACC_W-1:0] w_shift;
            assign w_shift = w_next >>> LOG2W;
            assign o_final = TOTAL_BITS'(w_shift);
        end else if (MODE == MODE_SUM) begin : g_finSum
`ifdef POOL_SAT_EN
            logic [63:0] w_sat;
            assign w_sat   = sat_signed(64'(w_next), ACC_W, TOTAL_BITS);
            assign o_final = TOTAL_BITS'(w_sat);
`else
            assign o_final = TOTAL_BITS'(w_next);
`endif
        end else begin : g_finMax
            assign o_final = TOTAL_BITS'(w_next);
        end
    endgenerate

endmodule

// File: rtl/pool_reduce_stream.sv
// Streaming multi-lane pooling reducer (sum/max/mean over WINDOW beats) with a one-entry output register.
// Define POOL_SAT_EN to saturate sum-mode results instead of wrapping.
module pool_reduce_stream
    import pool_pkg::*;
#(
    parameter int TOTAL_BITS = 16,
    parameter int Q          = 12,
    parameter int LANES      = 4,
    parameter int WINDOW     = 4,
    parameter int MODE       = MODE_MAX
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*TOTAL_BITS-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*TOTAL_BITS-1:0] out_data
);

    localparam int LOG2W = clog2(WINDOW);

    generate
        if (Q >= TOTAL_BITS || (1 << LOG2W) != WINDOW || WINDOW < 2) begin : g_badParams
            $error("pool_reduce_stream: WINDOW must be a power of two >= 2 and Q < TOTAL_BITS");
        end
    endgenerate

    logic [LOG2W-1:0]            r_cnt;
    logic                        r_outValid;
    logic [LANES*TOTAL_BITS-1:0] r_outData;
    logic [LANES*TOTAL_BITS-1:0] w_laneFinal;
    logic                        w_accept;
    logic                        w_first;
    logic                        w_last;

    // A stalled result blocks every beat, not only the final one of a window.
    assign in_ready  = ~r_outValid | out_ready;
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_first   = (r_cnt == '0);
    assign w_last    = (r_cnt == LOG2W'(WINDOW - 1));
    assign out_valid = r_outValid;
    assign out_data  = r_outData;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + LOG2W'(1);
        end
    end

    // A new final beat wins over the drain so back-to-back results never bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (w_accept && w_last) begin
            r_outValid <= 1'b1;
            r_outData  <= w_laneFinal;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            pool_lane #(
                .TOTAL_BITS(TOTAL_BITS),
                .WINDOW    (WINDOW),
                .MODE      (MODE)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .i_accept(w_accept),
                .i_first (w_first),
                .i_data  (in_data[k*TOTAL_BITS +: TOTAL_BITS]),
                .o_final (w_laneFinal[k*TOTAL_BITS +: TOTAL_BITS])
            );
        end
    endgenerate

endmodule
